lsu_mem_master: RTL and testbench

- Load/store initiator in the MEM pipeline stage; drives the word-addressed, single-port data memory (1-cycle registered read latency, no byte enables).
- Accepts byte/half/word loads and stores from the pipeline, converts byte addresses to word indices and sign/zero-extends load data.
- Implements sub-word stores as read-modify-write, since the memory only writes whole words.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_mem_master.sv | 161 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: access sizes, FSM states
// and the default word-index width.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LD_WAIT  = 2'b01,
        RMW_WAIT = 2'b10,
        RMW_WR   = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load lane extract with sign/zero extension, and
// sub-word store merge into a full memory word (little-endian lanes).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  lsu_size_e   size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [15:0] lane;

    assign shamt = {offset, 3'b000};

    always_comb begin
        lane      = 16'(rdata >> shamt);
        load_data = rdata;
        merged    = wdata;
        case (size)
            SZ_B: begin
                load_data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
                merged    = (rdata & ~(32'h0000_00FF << shamt)) | ({24'h0, wdata[7:0]} << shamt);
            end
            SZ_H: begin
                load_data = {{16{~is_unsigned & lane[15]}}, lane};
                merged    = (rdata & ~(32'h0000_FFFF << shamt)) | ({16'h0, wdata[15:0]} << shamt);
            end
            default: begin
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store master for a word-addressed single-port memory; sub-word
// stores run as read-modify-write. LSU_MISALIGN_TRAP_EN enables misalignment trapping.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        misaligned_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_write_o,
    output logic        data_write_enable_o,
    output logic        data_read_enable_o,
    input  logic [31:0] data_read_i
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] req_idx, idx_q, strobe_idx;
    lsu_size_e         req_size, size_q;
    logic [1:0]        req_off, off_q;
    logic              req_bad, accept, uns_q;
    logic [31:0]       wdata_q, merged_q, load_data, merged;
    logic              resp_valid_q, mis_q;
    logic [31:0]       rdata_q;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[31:ADDR_W+2];

    always_comb begin
        req_idx  = req_addr_i[ADDR_W+1:2];
        req_size = lsu_size_e'(req_size_i);
        req_bad  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_size)
            SZ_H:    req_bad = req_addr_i[0];
            SZ_W:    req_bad = |req_addr_i[1:0];
            SZ_X:    req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
`else
        if (req_size == SZ_X) req_size = SZ_W;
`endif
        // Offset is forced to natural alignment; a trapped access never uses it.
        case (req_size)
            SZ_B:    req_off = req_addr_i[1:0];
            SZ_H:    req_off = {req_addr_i[1], 1'b0};
            default: req_off = 2'b00;
        endcase
    end

    assign req_ready_o = reset_i && (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    lsu_lane_align u_lane_align (
        .rdata       (data_read_i),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_comb begin
        state_d             = state_q;
        data_read_enable_o  = 1'b0;
        data_write_enable_o = 1'b0;
        strobe_idx          = '0;
        data_write_o        = '0;
        case (state_q)
            IDLE: begin
                if (accept && !req_bad) begin
                    strobe_idx = req_idx;
                    if (req_store_i && req_size == SZ_W) begin
                        data_write_enable_o = 1'b1;
                        data_write_o        = req_wdata_i;
                    end else begin
                        data_read_enable_o = 1'b1;
                        state_d            = req_store_i ? RMW_WAIT : LD_WAIT;
                    end
                end
            end
            LD_WAIT:  state_d = IDLE;
            RMW_WAIT: state_d = RMW_WR;
            RMW_WR: begin
                data_write_enable_o = 1'b1;
                strobe_idx          = idx_q;
                data_write_o        = merged_q;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!reset_i) begin
            data_read_enable_o  = 1'b0;
            data_write_enable_o = 1'b0;
            strobe_idx          = '0;
            data_write_o        = '0;
        end
        data_addr_o             = '0;
        data_addr_o[ADDR_W-1:0] = strobe_idx;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            mis_q        <= 1'b0;
            rdata_q      <= '0;
            idx_q        <= '0;
            size_q       <= SZ_B;
            off_q        <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            merged_q     <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            mis_q        <= 1'b0;
            rdata_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_bad) begin
                            resp_valid_q <= 1'b1;
                            mis_q        <= 1'b1;
                        end else if (req_store_i && req_size == SZ_W) begin
                            resp_valid_q <= 1'b1;
                        end
                        idx_q   <= req_idx;
                        size_q  <= req_size;
                        off_q   <= req_off;
                        uns_q   <= req_unsigned_i;
                        wdata_q <= req_wdata_i;
                    end
                end
                LD_WAIT: begin
                    resp_valid_q <= 1'b1;
                    rdata_q      <= load_data;
                end
                RMW_WAIT: merged_q <= merged;
                RMW_WR:   resp_valid_q <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign misaligned_o = mis_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-lane reference model with a response schedule,
// an environment memory with 1-cycle registered read, directed vectors.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid_i, req_ready_o, req_store_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, misaligned_o;
    logic [31:0] resp_rdata_o, data_addr_o, data_write_o, data_read_i;
    logic        data_write_enable_o, data_read_enable_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_d   [int];
    bit          exp_m   [int];

    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(8)) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_store_i         (req_store_i),
        .req_size_i          (req_size_i),
        .req_unsigned_i      (req_unsigned_i),
        .req_addr_i          (req_addr_i),
        .req_wdata_i         (req_wdata_i),
        .resp_valid_o        (resp_valid_o),
        .resp_rdata_o        (resp_rdata_o),
        .misaligned_o        (misaligned_o),
        .data_addr_o         (data_addr_o),
        .data_write_o        (data_write_o),
        .data_write_enable_o (data_write_enable_o),
        .data_read_enable_o  (data_read_enable_o),
        .data_read_i         (data_read_i)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (data_write_enable_o) mem[data_addr_o[7:0]] <= data_write_o;
        if (data_read_enable_o) data_read_i <= mem[data_addr_o[7:0]];
        if (data_write_enable_o) wr_count <= wr_count + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (exp_d.exists(cyc)) begin
            chk("resp_valid", 32'(resp_valid_o), 32'd1);
            chk("resp_rdata", resp_rdata_o, exp_d[cyc]);
            chk("misaligned", 32'(misaligned_o), 32'(exp_m[cyc]));
            exp_d.delete(cyc);
            exp_m.delete(cyc);
        end else begin
            chk("resp_quiet", 32'(resp_valid_o), 32'd0);
        end
    end

    task automatic preload(input int idx, input logic [31:0] v);
        pl_idx = 8'(idx);
        pl_val = v;
        pl_en  = 1'b1;
        @(negedge clk);
        pl_en  = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic chk_mem(input string nm, input int idx);
        chk(nm, mem[idx], ref_mem[idx]);
    endtask

    // Called just after a falling edge; returns just after the falling edge of T+1.
    task automatic do_req(input string nm, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] lit);
        int idx, off, esz, lat, n;
        bit bad, got, wstore;
        logic [31:0] w, rd;
        idx = int'(addr >> 2) % 256;
        off = int'(addr[1:0]);
        esz = int'(sz);
        bad = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd3 || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)) bad = 1'b1;
`else
        if (esz == 3) esz = 2;
        if (esz == 1) off = off - (off % 2);
        if (esz == 2) off = 0;
`endif
        n = (esz == 0) ? 1 : (esz == 1) ? 2 : 4;
        rd = '0;
        wstore = !bad && st && esz == 2;
        if (bad) begin
            lat = 1;
        end else if (st) begin
            w = ref_mem[idx];
            for (int b = 0; b < n; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
            ref_mem[idx] = w;
            lat = (esz == 2) ? 1 : 3;
        end else begin
            w = ref_mem[idx];
            for (int b = 0; b < n; b++) rd[8*b +: 8] = w[8*(off+b) +: 8];
            if (!uns && n < 4 && rd[8*n-1])
                for (int b = n; b < 4; b++) rd[8*b +: 8] = 8'hFF;
            lat = 2;
        end
        chk({nm, "_model"}, st ? ref_mem[idx] : rd, lit);

        req_store_i    = st;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wd;
        req_valid_i    = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (req_ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ready: got 0 expected 1 within 40 cycles", nm);
        end else begin
            chk({nm, "_re"}, 32'(data_read_enable_o), 32'(!bad && !wstore));
            chk({nm, "_we"}, 32'(data_write_enable_o), 32'(wstore));
            chk({nm, "_addr"}, data_addr_o, bad ? 32'd0 : 32'(idx));
            chk({nm, "_wdata"}, data_write_o, wstore ? wd : 32'd0);
            exp_d[cyc + lat] = rd;
            exp_m[cyc + lat] = bad;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        req_store_i = 1'b0;
        req_size_i  = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        reset_i = 1'b0;
        req_valid_i = 1'b0; req_store_i = 1'b0; req_unsigned_i = 1'b0;
        req_size_i = '0; req_addr_i = '0; req_wdata_i = '0;
        repeat (3) @(negedge clk);
        req_valid_i = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_re", 32'(data_read_enable_o), 32'd0);
        chk("rst_we", 32'(data_write_enable_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        req_valid_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);

        preload(32'h20, 32'h8070FF01);
        preload(16, 32'h11223344);

        do_req("sw", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
        do_req("lw", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF);
        do_req("lb82", 0, 2'd0, 0, 32'h82, 32'h0, 32'h00000070);
        do_req("lb81", 0, 2'd0, 0, 32'h81, 32'h0, 32'hFFFFFFFF);
        do_req("lbu81", 0, 2'd0, 1, 32'h81, 32'h0, 32'h000000FF);
        do_req("lh82", 0, 2'd1, 0, 32'h82, 32'h0, 32'hFFFF8070);
        do_req("lhu82", 0, 2'd1, 1, 32'h82, 32'h0, 32'h00008070);

        do_req("sb41", 1, 2'd0, 0, 32'h41, 32'h000000AA, 32'h1122AA44);
        #1;
        chk("sb_busy1", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        #1;
        chk("sb_busy2", 32'(req_ready_o), 32'd0);
        chk("sb_wr_we", 32'(data_write_enable_o), 32'd1);
        chk("sb_wr_addr", data_addr_o, 32'h10);
        chk("sb_wr_data", data_write_o, 32'h1122AA44);
        @(negedge clk);
        chk_mem("sb_mem", 16);

        preload(16, 32'h11223344);
        do_req("sh42", 1, 2'd1, 0, 32'h42, 32'h0000BEEF, 32'hBEEF3344);
        repeat (2) @(negedge clk);
        chk_mem("sh_mem", 16);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw13", 0, 2'd2, 0, 32'h13, 32'h0, 32'h0);
        do_req("lh83", 0, 2'd1, 0, 32'h83, 32'h0, 32'h0);
        do_req("sz3", 0, 2'd3, 0, 32'h10, 32'h0, 32'h0);
        preload(16, 32'h11223344);
        do_req("sh41", 1, 2'd1, 0, 32'h41, 32'h5555CAFE, 32'h11223344);
`else
        do_req("lw13", 0, 2'd2, 0, 32'h13, 32'h0, 32'hDEADBEEF);
        do_req("lh83", 0, 2'd1, 0, 32'h83, 32'h0, 32'hFFFF8070);
        do_req("sz3", 0, 2'd3, 0, 32'h10, 32'h0, 32'hDEADBEEF);
        preload(16, 32'h11223344);
        do_req("sh41", 1, 2'd1, 0, 32'h41, 32'h5555CAFE, 32'h1122CAFE);
`endif
        repeat (3) @(negedge clk);
        chk_mem("sh41_mem", 16);

        do_req("sw_wrap", 1, 2'd2, 0, 32'h0000040C, 32'hCAFEF00D, 32'hCAFEF00D);
        do_req("lw_wrap", 0, 2'd2, 0, 32'h0000000C, 32'h0, 32'hCAFEF00D);
        repeat (2) @(negedge clk);

        preload(16, 32'h11223344);
        wc = wr_count;
        do_req("sb_rst", 1, 2'd0, 0, 32'h41, 32'h000000AA, 32'h1122AA44);
        ref_mem[16] = 32'h11223344;
        exp_d.delete();
        exp_m.delete();
        reset_i = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready_o), 32'd0);
        chk("midrst_we", 32'(data_write_enable_o), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("inrst_we", 32'(data_write_enable_o), 32'd0);
            chk("inrst_addr", data_addr_o, 32'd0);
        end
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("rst_release_ready", 32'(req_ready_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_no_write", 32'(wr_count), 32'(wc));
        chk_mem("rst_mem", 16);

        do_req("lw_after_rst", 0, 2'd2, 0, 32'h40, 32'h0, 32'h11223344);
        repeat (4) @(negedge clk);
        chk("pending_resp", 32'(exp_d.num()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
